uart_core_param: RTL and testbench

//   Parametrised full-duplex UART: runtime-free baud generator, TX serialiser and
//   16x-oversampled RX deserialiser in one block. Configurable width, parity and stop bits.

---
 rtl/uart_core_param.sv | 217 +++++++++++++++++++++
 tb/tb_uart_core_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
// uart_core_param
//   Full-duplex UART: shared baud divider, TX serialiser and oversampled RX
//   deserialiser with parity/framing/overrun reporting, start-bit glitch
//   rejection and an internal loopback path for self-test.
// Ports
//   clk, rst            system clock, async active-high reset
//   loopback            1: RX fed from internal TX line, tx pin forced high
//   tx_req/tx_data      send request and word (latched on accept)
//   tx_ack              high in the accept cycle (idle && tx_req)
//   tx_busy             frame in progress
//   tx                  serial out, idle high
//   rx                  serial in, asynchronous
//   rx_rdy/rx_data      received word, held until rx_ack
//   rx_perr/rx_ferr     parity / framing error for rx_data
//   rx_overrun          frame dropped while rx_rdy was high (sticky until ack)
//   rx_ack              consumer took rx_data
module uart_core_param #(
  parameter int    DATA_BITS  = 8,
  parameter string PARITY     = "ODD",
  parameter int    STOP_BITS  = 1,
  parameter int    CLK_HZ     = 50_000_000,
  parameter int    BAUD       = 115_200,
  parameter int    OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 loopback,
  input  logic                 tx_req,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ack,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic                 rx_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_overrun,
  input  logic                 rx_ack
);

  localparam int DIV_RAW   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int BIT_CLKS  = OVERSAMPLE * DIV;
  localparam int STOP_CLKS = STOP_BITS * BIT_CLKS;
  localparam int DCW       = $clog2(DIV + 1);
  localparam int TCW       = $clog2(STOP_CLKS + 1);
  localparam int OCW       = $clog2(OVERSAMPLE);
  localparam int BCW       = $clog2(DATA_BITS + 1);
  localparam bit HAS_PAR   = (PARITY != "NONE");
  localparam bit ODD_PAR   = (PARITY == "ODD");

  // ---------------- baud divider ----------------
  logic [DCW-1:0] div_cnt;
  logic           os_tick;

  assign os_tick = (div_cnt == DCW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          div_cnt <= '0;
    else if (os_tick) div_cnt <= '0;
    else              div_cnt <= div_cnt + 1'b1;
  end

  // ---------------- TX ----------------
  // TX times bits in raw clocks with its own counter so a frame starts on the
  // accept edge rather than waiting for the next os_tick.
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;

  tx_state_t            tx_st;
  logic [TCW-1:0]       tx_cnt;
  logic [BCW-1:0]       tx_idx;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_line;
  logic                 tx_bit_end;

  assign tx_ack     = !rst && (tx_st == T_IDLE) && tx_req;
  assign tx_bit_end = (tx_cnt == TCW'(BIT_CLKS - 1));
  assign tx         = loopback ? 1'b1 : tx_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st   <= T_IDLE;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sh   <= '0;
      tx_par  <= 1'b0;
      tx_line <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (tx_st)
        T_IDLE: if (tx_req) begin
          tx_sh   <= tx_data;
          tx_par  <= ODD_PAR ? ~(^tx_data) : ^tx_data;
          tx_cnt  <= '0;
          tx_line <= 1'b0;
          tx_busy <= 1'b1;
          tx_st   <= T_START;
        end
        T_START: if (tx_bit_end) begin
          tx_cnt  <= '0;
          tx_line <= tx_sh[0];
          tx_sh   <= tx_sh >> 1;
          tx_idx  <= '0;
          tx_st   <= T_DATA;
        end else tx_cnt <= tx_cnt + 1'b1;
        T_DATA: if (tx_bit_end) begin
          tx_cnt <= '0;
          if (tx_idx == BCW'(DATA_BITS - 1)) begin
            tx_line <= HAS_PAR ? tx_par : 1'b1;
            tx_st   <= HAS_PAR ? T_PAR : T_STOP;
          end else begin
            tx_line <= tx_sh[0];
            tx_sh   <= tx_sh >> 1;
            tx_idx  <= tx_idx + 1'b1;
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        T_PAR: if (tx_bit_end) begin
          tx_cnt  <= '0;
          tx_line <= 1'b1;
          tx_st   <= T_STOP;
        end else tx_cnt <= tx_cnt + 1'b1;
        T_STOP: if (tx_cnt == TCW'(STOP_CLKS - 1)) begin
          tx_cnt  <= '0;
          tx_busy <= 1'b0;
          tx_st   <= T_IDLE;
        end else tx_cnt <= tx_cnt + 1'b1;
        default: tx_st <= T_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

  rx_state_t            rx_st;
  logic [1:0]           sync;
  logic                 rx_s;
  logic [OCW-1:0]       os_cnt;
  logic [BCW-1:0]       rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_pbit;
  logic                 rx_mid;
  logic                 rx_half;
  logic                 par_err;

  assign rx_s    = sync[1];
  assign rx_half = os_tick && (os_cnt == OCW'(OVERSAMPLE / 2 - 1));
  assign rx_mid  = os_tick && (os_cnt == OCW'(OVERSAMPLE - 1));
  assign par_err = HAS_PAR && (((^rx_sh) ^ rx_pbit) != ODD_PAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], loopback ? tx_line : rx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_st      <= R_IDLE;
      os_cnt     <= '0;
      rx_idx     <= '0;
      rx_sh      <= '0;
      rx_pbit    <= 1'b0;
      rx_rdy     <= 1'b0;
      rx_data    <= '0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_ack && rx_rdy) begin
        rx_rdy     <= 1'b0;
        rx_overrun <= 1'b0;
      end
      case (rx_st)
        R_IDLE: begin
          os_cnt <= '0;
          if (!rx_s) rx_st <= R_START;
        end
        // half-bit resample: a line back high here was a glitch
        R_START: if (rx_half) begin
          os_cnt <= '0;
          rx_idx <= '0;
          rx_st  <= rx_s ? R_IDLE : R_DATA;
        end else if (os_tick) os_cnt <= os_cnt + 1'b1;
        R_DATA: if (rx_mid) begin
          os_cnt <= '0;
          rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
          if (rx_idx == BCW'(DATA_BITS - 1)) rx_st <= HAS_PAR ? R_PAR : R_STOP;
          else                               rx_idx <= rx_idx + 1'b1;
        end else if (os_tick) os_cnt <= os_cnt + 1'b1;
        R_PAR: if (rx_mid) begin
          os_cnt  <= '0;
          rx_pbit <= rx_s;
          rx_st   <= R_STOP;
        end else if (os_tick) os_cnt <= os_cnt + 1'b1;
        R_STOP: if (rx_mid) begin
          os_cnt <= '0;
          // an ack in this same cycle frees the holding register
          if (!rx_rdy || rx_ack) begin
            rx_data <= rx_sh;
            rx_perr <= par_err;
            rx_ferr <= !rx_s;
            rx_rdy  <= 1'b1;
          end else begin
            rx_overrun <= 1'b1;
          end
          // a low stop bit (break) must see the line high before re-arming
          rx_st <= rx_s ? R_IDLE : R_WAIT;
        end else if (os_tick) os_cnt <= os_cnt + 1'b1;
        R_WAIT: if (rx_s) rx_st <= R_IDLE;
        default: rx_st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param
//   Randomised bench for uart_core_param at 16 clk per bit (DIV=1). One ODD
//   instance covers loopback, RX error paths and reset; one EVEN instance
//   covers TX line timing. Expected frames come from a bit-list model.
module tb_uart_core_param;

  localparam int NB  = 11;        // start + 8 data + parity + 1 stop
  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ODD instance
  logic       lb, tq, ta, tb_busy, txo, rxi, rr, rpe, rfe, rov, rack;
  logic [7:0] td, rd;
  // EVEN instance
  logic       tq_e, ta_e, busy_e, tx_e, rr_e, rpe_e, rfe_e, rov_e;
  logic [7:0] td_e, rd_e;

  uart_core_param #(.DATA_BITS(8), .PARITY("ODD"), .STOP_BITS(1),
                    .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .loopback(lb), .tx_req(tq), .tx_data(td),
    .tx_ack(ta), .tx_busy(tb_busy), .tx(txo), .rx(rxi), .rx_rdy(rr),
    .rx_data(rd), .rx_perr(rpe), .rx_ferr(rfe), .rx_overrun(rov), .rx_ack(rack));

  uart_core_param #(.DATA_BITS(8), .PARITY("EVEN"), .STOP_BITS(1),
                    .CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16)) dut_e (
    .clk(clk), .rst(rst), .loopback(1'b0), .tx_req(tq_e), .tx_data(td_e),
    .tx_ack(ta_e), .tx_busy(busy_e), .tx(tx_e), .rx(1'b1), .rx_rdy(rr_e),
    .rx_data(rd_e), .rx_perr(rpe_e), .rx_ferr(rfe_e), .rx_overrun(rov_e), .rx_ack(1'b1));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // line bits LSB first: start, data, parity, stop, idle
  function automatic logic [15:0] frame(input logic [7:0] d, input bit ev,
                                        input bit pok, input bit stp);
    bit p;
    p = (($countones(d) % 2) == 1) ? ev : !ev;
    if (!pok) p = !p;
    frame = {5'b11111, stp, p, d, 1'b0};
  endfunction

  task automatic ack(input string tag);
    rack = 1'b1;
    @(negedge clk);
    rack = 1'b0;
    chk({tag, "_rdy_clr"}, rr, 1'b0);
    chk({tag, "_ovr_clr"}, rov, 1'b0);
  endtask

  // send one word; EVEN instance checks the line, ODD in loopback checks the echo
  task automatic tx_run(input bit ev, input logic [7:0] d, input string tag);
    logic [15:0] f;
    int bad, busy_bad, rdy_at;
    bit pin_hi;
    logic pin;
    f = frame(d, ev, 1'b1, 1'b1);
    bad = 0; busy_bad = 0; rdy_at = -1; pin_hi = 1'b1;
    if (ev) begin tq_e = 1'b1; td_e = d; end
    else    begin tq   = 1'b1; td   = d; end
    #1 chk({tag, "_ack"}, ev ? ta_e : ta, 1'b1);
    @(negedge clk);
    tq = 1'b0; tq_e = 1'b0;
    chk({tag, "_ack_pulse"}, ev ? ta_e : ta, 1'b0);
    for (int k = 0; k < NB * BIT; k++) begin
      pin = ev ? tx_e : txo;
      if (!ev && lb) begin
        if (pin !== 1'b1) pin_hi = 1'b0;
      end else if (pin !== f[k / BIT]) bad++;
      if ((ev ? busy_e : tb_busy) !== 1'b1) busy_bad++;
      if (!ev && rr === 1'b1 && rdy_at < 0) rdy_at = k;
      @(negedge clk);
    end
    chk({tag, "_busy_lo"}, ev ? busy_e : tb_busy, 1'b0);
    chk({tag, "_busy_frame"}, busy_bad, 0);
    if (!ev && lb) begin
      chk({tag, "_pin_hi"}, pin_hi, 1'b1);
      for (int w = 0; w < 10 && rdy_at < 0; w++) begin
        if (rr === 1'b1) rdy_at = NB * BIT + w;
        else @(negedge clk);
      end
      chk({tag, "_latency"}, (rdy_at >= (NB - 1) * BIT) && (rdy_at <= NB * BIT + 10), 1'b1);
      chk({tag, "_data"}, rd, d);
      chk({tag, "_perr"}, rpe, 1'b0);
      chk({tag, "_ferr"}, rfe, 1'b0);
      ack(tag);
    end else begin
      chk({tag, "_bits"}, bad, 0);
    end
  endtask

  task automatic rx_drive(input logic [15:0] f);
    for (int i = 0; i < NB; i++) begin
      rxi = f[i];
      repeat (BIT) @(negedge clk);
    end
    rxi = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic rx_chk(input logic [7:0] d, input bit pok, input bit stp, input string tag);
    chk({tag, "_idle"}, rr, 1'b0);
    rx_drive(frame(d, 1'b0, pok, stp));
    chk({tag, "_rdy"}, rr, 1'b1);
    chk({tag, "_data"}, rd, d);
    chk({tag, "_perr"}, rpe, !pok);
    chk({tag, "_ferr"}, rfe, !stp);
    chk({tag, "_ovr"}, rov, 1'b0);
    ack(tag);
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int rises, seen;
    logic [7:0] got_d;
    logic got_f;
    lb = 1'b0; tq = 1'b0; td = '0; rxi = 1'b1; rack = 1'b0;
    tq_e = 1'b0; td_e = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", txo, 1'b1);
    chk("rst_busy", tb_busy, 1'b0);
    chk("rst_ack", ta, 1'b0);
    chk("rst_rdy", rr, 1'b0);
    chk("rst_ovr", rov, 1'b0);
    chk("rst_perr", rpe, 1'b0);
    chk("rst_ferr", rfe, 1'b0);
    chk("rst_data", rd, 8'h00);
    chk("rst_e", {rr_e, rov_e, rpe_e, rfe_e, busy_e, rd_e}, '0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // loopback: rx pin held low to show it is ignored
    lb = 1'b1; rxi = 1'b0;
    tx_run(1'b0, 8'h55, "lb55");
    for (int i = 0; i < 5; i++) tx_run(1'b0, 8'($urandom_range(0, 255)), "lb_rnd");
    rxi = 1'b1;
    repeat (4) @(negedge clk);
    lb = 1'b0;
    repeat (20) @(negedge clk);

    // EVEN line waveform
    tx_run(1'b1, 8'hA5, "evA5");
    for (int i = 0; i < 3; i++) tx_run(1'b1, 8'($urandom_range(0, 255)), "ev_rnd");

    // RX errors
    rx_chk(8'h3C, 1'b0, 1'b1, "perr3C");
    for (int i = 0; i < 8; i++)
      rx_chk(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rx_rnd");

    // break: stop low, line held low 30 more bits -> exactly one frame
    begin
      logic [15:0] f;
      f = frame(8'h3C, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < NB - 1; i++) begin
        rxi = f[i];
        repeat (BIT) @(negedge clk);
      end
      rxi = 1'b0;
      rises = 0; got_d = '0; got_f = 1'b0;
      for (int c = 0; c < 31 * BIT + 48; c++) begin
        if (c == 31 * BIT) rxi = 1'b1;
        if (rr === 1'b1 && rack == 1'b0) begin
          rises++; got_d = rd; got_f = rfe; rack = 1'b1;
        end else rack = 1'b0;
        @(negedge clk);
      end
      rack = 1'b0;
      @(negedge clk);
      chk("brk_frames", rises, 1);
      chk("brk_data", got_d, 8'h3C);
      chk("brk_ferr", got_f, 1'b1);
      chk("brk_rdy", rr, 1'b0);
    end

    // overrun: second frame dropped, first kept
    rx_drive(frame(8'h11, 1'b0, 1'b1, 1'b1));
    rx_drive(frame(8'h22, 1'b0, 1'b1, 1'b1));
    chk("ovr_rdy", rr, 1'b1);
    chk("ovr_data", rd, 8'h11);
    chk("ovr_flag", rov, 1'b1);
    ack("ovr");

    // 4-clk glitch is rejected, receiver then still works
    rxi = 1'b0;
    repeat (4) @(negedge clk);
    rxi = 1'b1;
    seen = 0;
    repeat (300) begin
      if (rr === 1'b1) seen = 1;
      @(negedge clk);
    end
    chk("glitch_none", seen, 0);
    rx_chk(8'($urandom_range(0, 255)), 1'b1, 1'b1, "post_glitch");

    // reset mid-TX frame
    tq = 1'b1; td = 8'hF0;
    @(negedge clk);
    tq = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_rst_tx", txo, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", txo, 1'b1);
    chk("rst_mid_busy", tb_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (250) begin
      if (rr === 1'b1 || txo !== 1'b1 || tb_busy !== 1'b0) seen = 1;
      @(negedge clk);
    end
    chk("rst_no_residue", seen, 0);
    lb = 1'b1;
    tx_run(1'b0, 8'($urandom_range(0, 255)), "post_rst");
    chk("e_rx_quiet", {rr_e, rov_e}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
